serial_sub_ctrl: RTL and testbench

Bit-serial subtraction controller that computes a WIDTH-bit difference `a - b - bin` by driving a single `full_sub` cell one bit per clock, LSB first. It latches the operands on a start request, sequences the cell through WIDTH bit-slices while holding the running borrow in a register, then presents the registered result with a one-cycle done pulse. It is the area-minimal alternative to a WIDTH-wide ripple subtractor and feeds multi-cycle arithmetic paths that tolerate WIDTH-cycle latency.

---
 rtl/serial_sub_ctrl.sv | 116 +++++++++++
 tb/tb_serial_sub_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: a single full_sub cell is stepped LSB-first over WIDTH
// clocks, with the running borrow kept in a register between bit-slices.

module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borr
);
  assign diff = a ^ b ^ bin;
  assign borr = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borr,
  output logic             ovf
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] aSh_q, bSh_q, res_q, res_d, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             brw_q, busy_q, done_q, borr_q, ovf_q;
  logic             cellDiff, cellBorr, lastBit;

  full_sub uCell (
    .a    (aSh_q[0]),
    .b    (bSh_q[0]),
    .bin  (brw_q),
    .diff (cellDiff),
    .borr (cellBorr)
  );

  assign lastBit = (cnt_q == CW'(WIDTH - 1));

  // Result bits enter at the MSB so that after WIDTH shifts the LSB lands in bit 0.
  if (WIDTH == 1) begin : gNarrow
    assign res_d = cellDiff;
  end else begin : gWide
    assign res_d = {cellDiff, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      aSh_q   <= '0;
      bSh_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      borr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            aSh_q   <= a;
            bSh_q   <= b;
            brw_q   <= bin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          aSh_q <= aSh_q >> 1;
          bSh_q <= bSh_q >> 1;
          brw_q <= cellBorr;
          res_q <= res_d;
          cnt_q <= cnt_q + CW'(1);
          // On the last slice the operand LSBs are the original sign bits.
          if (lastBit) begin
            diff_q  <= res_d;
            borr_q  <= cellBorr;
            ovf_q   <= (aSh_q[0] != bSh_q[0]) && (cellDiff != aSh_q[0]);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign borr = borr_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH 8, 4 and 1 sharing one clock and reset.

module tb_serial_sub_ctrl;
  logic clk = 1'b0;
  logic rst;

  logic       start8, bin8, busy8, done8, borr8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, borr4, ovf4;
  logic [3:0] a4, b4, diff4;
  logic       start1, bin1, busy1, done1, borr1, ovf1;
  logic [0:0] a1, b1, diff1;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .borr(borr8), .ovf(ovf8)
  );
  serial_sub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borr(borr4), .ovf(ovf4)
  );
  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .borr(borr1), .ovf(ovf1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference for the exhaustive sweeps: plain integer arithmetic, signed range test for ovf.
  task automatic refSub(input int w, input int av, input int bv, input int bnv,
                        output int d, output int br, output int ov);
    int full, sa, sb, sr;
    full = av - bv - bnv;
    d    = full & ((1 << w) - 1);
    br   = (full < 0) ? 1 : 0;
    sa   = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
    sb   = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
    sr   = sa - sb - bnv;
    ov   = (sr > (1 << (w - 1)) - 1 || sr < -(1 << (w - 1))) ? 1 : 0;
  endtask

  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic bnv,
                      output int lat, output int busyCnt);
    a8 = av; b8 = bv; bin8 = bnv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0; busyCnt = 0;
    while (done8 !== 1'b1 && lat < 20) begin
      if (busy8 === 1'b1) busyCnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({busy8, done8, diff8, borr8, ovf8} !== 12'h000) begin
      fails++;
      $display("[TB] FAIL reset8: got busy=%b done=%b diff=%h borr=%b ovf=%b, want all 0",
               busy8, done8, diff8, borr8, ovf8);
    end
    checks++;
    if ({busy4, done4, diff4, borr4, ovf4} !== 8'h00 ||
        {busy1, done1, diff1, borr1, ovf1} !== 5'h00) begin
      fails++;
      $display("[TB] FAIL reset4_1: got w4=%b w1=%b, want all 0",
               {busy4, done4, diff4, borr4, ovf4}, {busy1, done1, diff1, borr1, ovf1});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, busyCnt;
    run8(8'h5A, 8'h3C, 1'b0, lat, busyCnt);
    checks++;
    if (lat != 8 || busyCnt != 8) begin
      fails++;
      $display("[TB] FAIL basic_latency: got lat=%0d busy=%0d, want lat=8 busy=8", lat, busyCnt);
    end
    checks++;
    if (diff8 !== 8'h1E || borr8 !== 1'b0 || ovf8 !== 1'b0 || busy8 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_result: got diff=%h borr=%b ovf=%b busy=%b, want 1e 0 0 0",
               diff8, borr8, ovf8, busy8);
    end
    tick();
    checks++;
    if (done8 !== 1'b0 || diff8 !== 8'h1E) begin
      fails++;
      $display("[TB] FAIL basic_pulse: got done=%b diff=%h, want done=0 diff=1e", done8, diff8);
    end
  endtask

  task automatic test_borrow_ovf();
    logic [7:0] va [4] = '{8'h00, 8'h80, 8'h10, 8'h00};
    logic [7:0] vb [4] = '{8'h01, 8'h01, 8'h0F, 8'h00};
    logic       vn [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] vd [4] = '{8'hFF, 8'h7F, 8'h00, 8'hFF};
    logic       vr [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       vo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int lat, busyCnt;
    for (int i = 0; i < 4; i++) begin
      run8(va[i], vb[i], vn[i], lat, busyCnt);
      checks++;
      if (lat != 8 || diff8 !== vd[i] || borr8 !== vr[i] || ovf8 !== vo[i]) begin
        fails++;
        $display("[TB] FAIL vec%0d: got diff=%h borr=%b ovf=%b lat=%0d, want diff=%h borr=%b ovf=%b lat=8",
                 i, diff8, borr8, ovf8, lat, vd[i], vr[i], vo[i]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [3] = '{8'h12, 8'hF0, 8'h7F};
    logic [7:0] ob [3] = '{8'h34, 8'h0F, 8'hFF};
    logic       on [3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] od [3] = '{8'hDE, 8'hE0, 8'h80};
    logic       orr[3] = '{1'b1, 1'b0, 1'b1};
    logic       oo [3] = '{1'b0, 1'b0, 1'b1};
    int idx = 0, cyc = 0, lastDone = 0;
    bit overlap = 0;
    a8 = oa[0]; b8 = ob[0]; bin8 = on[0]; start8 = 1'b1;
    tick();
    while (idx < 3 && cyc < 60) begin
      if (busy8 === 1'b1 && done8 === 1'b1) overlap = 1;
      if (done8 === 1'b1) begin
        checks++;
        if (diff8 !== od[idx] || borr8 !== orr[idx] || ovf8 !== oo[idx] ||
            cyc - lastDone != ((idx == 0) ? 8 : 9)) begin
          fails++;
          $display("[TB] FAIL b2b%0d: got diff=%h borr=%b ovf=%b gap=%0d, want diff=%h borr=%b ovf=%b gap=%0d",
                   idx, diff8, borr8, ovf8, cyc - lastDone, od[idx], orr[idx], oo[idx],
                   (idx == 0) ? 8 : 9);
        end
        lastDone = cyc;
        idx++;
        if (idx < 3) begin
          a8 = oa[idx]; b8 = ob[idx]; bin8 = on[idx];
        end else begin
          start8 = 1'b0;
        end
      end else begin
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
      tick();
      cyc++;
    end
    start8 = 1'b0;
    checks++;
    if (idx != 3 || overlap || done8 !== 1'b0 || busy8 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_end: got ops=%0d overlap=%0d done=%b busy=%b, want ops=3 overlap=0 done=0 busy=0",
               idx, overlap, done8, busy8);
    end
  endtask

  task automatic test_reset_midrun();
    int lat, busyCnt;
    bit seenDone = 0;
    a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy8 !== 1'b1 || diff8 !== 8'h80 || borr8 !== 1'b1 || ovf8 !== 1'b1) begin
      fails++;
      $display("[TB] FAIL hold_during_run: got busy=%b diff=%h borr=%b ovf=%b, want 1 80 1 1",
               busy8, diff8, borr8, ovf8);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy8, done8, diff8, borr8, ovf8} !== 12'h000) begin
      fails++;
      $display("[TB] FAIL midrun_reset: got busy=%b done=%b diff=%h borr=%b ovf=%b, want all 0",
               busy8, done8, diff8, borr8, ovf8);
    end
    repeat (12) begin
      if (done8 !== 1'b0 || busy8 !== 1'b0) seenDone = 1;
      tick();
    end
    checks++;
    if (seenDone) begin
      fails++;
      $display("[TB] FAIL aborted_op: got done/busy activity after reset, want none");
    end
    run8(8'h33, 8'h11, 1'b0, lat, busyCnt);
    checks++;
    if (lat != 8 || diff8 !== 8'h22 || borr8 !== 1'b0 || ovf8 !== 1'b0) begin
      fails++;
      $display("[TB] FAIL after_reset: got diff=%h borr=%b ovf=%b lat=%0d, want 22 0 0 lat=8",
               diff8, borr8, ovf8, lat);
    end
    tick();
  endtask

  task automatic test_sweep4();
    int d, br, ov, lat;
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int bn = 0; bn < 2; bn++) begin
          refSub(4, av, bv, bn, d, br, ov);
          a4 = 4'(av); b4 = 4'(bv); bin4 = 1'(bn); start4 = 1'b1;
          tick();
          start4 = 1'b0;
          lat = 0;
          while (done4 !== 1'b1 && lat < 10) begin
            tick();
            lat++;
          end
          checks++;
          if (lat != 4 || diff4 !== 4'(d) || borr4 !== 1'(br) || ovf4 !== 1'(ov)) begin
            fails++;
            $display("[TB] FAIL sweep4 a=%0d b=%0d bin=%0d: got diff=%0d borr=%b ovf=%b lat=%0d, want diff=%0d borr=%0d ovf=%0d lat=4",
                     av, bv, bn, diff4, borr4, ovf4, lat, d, br, ov);
          end
        end
    tick();
  endtask

  task automatic test_sweep1();
    int d, br, ov, lat;
    for (int av = 0; av < 2; av++)
      for (int bv = 0; bv < 2; bv++)
        for (int bn = 0; bn < 2; bn++) begin
          refSub(1, av, bv, bn, d, br, ov);
          a1 = 1'(av); b1 = 1'(bv); bin1 = 1'(bn); start1 = 1'b1;
          tick();
          start1 = 1'b0;
          lat = 0;
          while (done1 !== 1'b1 && lat < 10) begin
            tick();
            lat++;
          end
          checks++;
          if (lat != 1 || diff1 !== 1'(d) || borr1 !== 1'(br) || ovf1 !== 1'(ov)) begin
            fails++;
            $display("[TB] FAIL sweep1 a=%0d b=%0d bin=%0d: got diff=%b borr=%b ovf=%b lat=%0d, want diff=%0d borr=%0d ovf=%0d lat=1",
                     av, bv, bn, diff1, borr1, ovf1, lat, d, br, ov);
          end
        end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    test_reset();
    test_basic();
    test_borrow_ovf();
    test_back_to_back();
    test_reset_midrun();
    test_sweep4();
    test_sweep1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
